wor_capture: RTL

Downstream measurement stage for the wired-OR net output `f`. It synchronises the single-bit `f` into the `clk` domain and counts two things over a fixed window of `WINDOW` clock cycles: cycles where `f` is high, and rising edges of `f`. Each finished window is offered as a result record on a valid/ready handshake. It lets the team observe and score wired-OR resolution in hardware instead of reading `$monitor` output.

---
 rtl/wor_capture_pkg.sv | 19 +
 rtl/wor_capture_sync2_edge.sv | 31 +++
 rtl/wor_capture.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wor_capture_pkg.sv
// Shared types for the wired-OR capture stage.
package wor_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } wor_cap_state_t;

  // Record width for consumers using the default counter width.
  localparam int unsigned WOR_CNT_W = 8;

  typedef struct packed {
    logic [WOR_CNT_W-1:0] high_count;
    logic [WOR_CNT_W-1:0] rise_count;
    logic                 overflow;
  } wor_cap_rec_t;

endpackage

// File: rtl/wor_capture_sync2_edge.sv
// Two-flop synchroniser for the asynchronous wired-OR net, plus a one-cycle
// history flop used to detect 0->1 transitions of the synchronised value.
module sync2_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic f_s_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain and previous-value history; runs every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign f_s_o  = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/wor_capture.sv
// Windowed measurement of the wired-OR net: counts high cycles and rising
// edges over WINDOW cycles and offers each result on a valid/ready port.
module wor_capture #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_in,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] rise_count,
  output logic             overflow
);
  import wor_capture_pkg::*;

  localparam int unsigned    WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  wor_cap_state_t   state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic             ov_q, ov_d;
  // Published record: loaded only when a window completes, so it stays
  // stable for the whole time out_valid is high.
  logic [CNT_W-1:0] rec_hc_q, rec_hc_d;
  logic [CNT_W-1:0] rec_rc_q, rec_rc_d;
  logic             rec_ov_q, rec_ov_d;
  logic             start_win;
  logic             f_s;
  logic             rise;

  sync2_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (f_in),
    .f_s_o  (f_s),
    .rise_o (rise)
  );

  // Next-state logic: FSM, window counter and saturating accumulators.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    hc_d      = hc_q;
    rc_d      = rc_q;
    ov_d      = ov_q;
    rec_hc_d  = rec_hc_q;
    rec_rc_d  = rec_rc_q;
    rec_ov_d  = rec_ov_q;
    start_win = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_MEASURE;
          start_win = 1'b1;
        end
      end
      ST_MEASURE: begin
        // Losing enable abandons the window; partial counts are never shown.
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          if (f_s) begin
            if (hc_q == CNT_MAX) ov_d = 1'b1;
            else                 hc_d = hc_q + 1'b1;
          end
          if (rise) begin
            if (rc_q == CNT_MAX) ov_d = 1'b1;
            else                 rc_d = rc_q + 1'b1;
          end
          if (win_q == WIN_LAST) begin
            state_d  = ST_REPORT;
            rec_hc_d = hc_d;
            rec_rc_d = rc_d;
            rec_ov_d = ov_d;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
      end
      ST_REPORT: begin
        // Record is held until taken; enable only picks where we go next.
        if (out_ready) begin
          if (enable) begin
            state_d   = ST_MEASURE;
            start_win = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_win) begin
      win_d    = '0;
      hc_d     = '0;
      rc_d     = '0;
      ov_d     = 1'b0;
      rec_hc_d = '0;
      rec_rc_d = '0;
      rec_ov_d = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      hc_q     <= '0;
      rc_q     <= '0;
      ov_q     <= 1'b0;
      rec_hc_q <= '0;
      rec_rc_q <= '0;
      rec_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      hc_q     <= hc_d;
      rc_q     <= rc_d;
      ov_q     <= ov_d;
      rec_hc_q <= rec_hc_d;
      rec_rc_q <= rec_rc_d;
      rec_ov_q <= rec_ov_d;
    end
  end

  assign out_valid  = (state_q == ST_REPORT);
  assign high_count = rec_hc_q;
  assign rise_count = rec_rc_q;
  assign overflow   = rec_ov_q;

endmodule
